ctrl_fsm: RTL and testbench

Multi-cycle control unit for the Lab2 8-bit datapath. It fetches an instruction word over a request/valid handshake and sequences it through decode, execute, optional memory access and writeback. It drives the control and select signals consumed by the datapath multiplexers, register file, ALU and data memory: register write enable, ALU operand-B select, result select, ALU function and register addresses.

---
 rtl/ctrl_pkg.sv | 38 +++
 rtl/ctrl_decode.sv | 104 ++++++++++
 rtl/ctrl_fsm.sv | 167 ++++++++++++++++
 tb/tb_ctrl_fsm.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared types and constants for the Lab2 multi-cycle control unit:
// FSM states, instruction classes, ALU function codes and IR field positions.
package ctrl_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_ERROR  = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        CLS_ALU_REG = 2'b00,
        CLS_ALU_IMM = 2'b01,
        CLS_LOAD    = 2'b10,
        CLS_STORE   = 2'b11
    } iclass_t;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_OR  = 2'b11;

    // The upper half of the 2N-bit IR holds four 2-bit fields, numbered from the MSB.
    localparam int FLD_W      = 2;
    localparam int CLASS_SLOT = 0;
    localparam int FUNC_SLOT  = 1;
    localparam int RDST_SLOT  = 2;
    localparam int SRC1_SLOT  = 3;
    localparam int SRC2_LO    = 0;

    function automatic int field_lo(input int n, input int slot);
        return 2 * n - FLD_W - FLD_W * slot;
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Moore output decoder: maps the current FSM state and the latched IR onto
// the datapath control and select signals. Purely combinational.
module ctrl_decode
    import ctrl_pkg::*;
#(
    parameter int N = 8
) (
    input  state_t         state,
    input  logic [2*N-1:0] ir,
    output logic           instr_req,
    output logic           mem_req,
    output logic           mem_we,
    output logic [1:0]     ra1,
    output logic [N-1:0]   src2,
    output logic [1:0]     rdst3,
    output logic           we,
    output logic           alu_src2,
    output logic           alu_or_m,
    output logic [1:0]     alu_ctrl
);

    localparam int CLS_LO  = field_lo(N, CLASS_SLOT);
    localparam int FUNC_LO = field_lo(N, FUNC_SLOT);
    localparam int RDST_LO = field_lo(N, RDST_SLOT);
    localparam int SRC1_LO = field_lo(N, SRC1_SLOT);

    iclass_t        cls_s;
    logic [1:0]     func_s;
    logic [1:0]     rdst_s;
    logic [1:0]     src1_s;
    logic [N-1:0]   src2_s;
    logic           fields_on_s;

    assign cls_s  = iclass_t'(ir[CLS_LO +: FLD_W]);
    assign func_s = ir[FUNC_LO +: FLD_W];
    assign rdst_s = ir[RDST_LO +: FLD_W];
    assign src1_s = ir[SRC1_LO +: FLD_W];
    assign src2_s = ir[SRC2_LO +: N];

    // Per-state control decode; register fields are exposed from DECODE until the next FETCH.
    always_comb begin
        instr_req   = 1'b0;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        we          = 1'b0;
        alu_src2    = 1'b0;
        alu_or_m    = 1'b0;
        alu_ctrl    = ALU_ADD;
        fields_on_s = 1'b0;
        case (state)
            ST_FETCH: begin
                instr_req = 1'b1;
            end
            ST_DECODE: begin
                fields_on_s = 1'b1;
            end
            ST_EXEC: begin
                fields_on_s = 1'b1;
                case (cls_s)
                    CLS_ALU_REG: begin
                        alu_ctrl = func_s;
                        alu_src2 = 1'b0;
                    end
                    CLS_ALU_IMM: begin
                        alu_ctrl = func_s;
                        alu_src2 = 1'b1;
                    end
                    CLS_LOAD: begin
                        alu_ctrl = ALU_ADD;
                        alu_src2 = 1'b1;
                    end
                    CLS_STORE: begin
                        alu_ctrl = ALU_ADD;
                        alu_src2 = 1'b0;
                    end
                    default: begin
                        alu_ctrl = ALU_ADD;
                        alu_src2 = 1'b0;
                    end
                endcase
            end
            ST_MEM: begin
                fields_on_s = 1'b1;
                mem_req     = 1'b1;
                mem_we      = (cls_s == CLS_STORE);
            end
            ST_WB: begin
                fields_on_s = 1'b1;
                we          = 1'b1;
                alu_or_m    = (cls_s == CLS_LOAD);
            end
            ST_ERROR: begin
                fields_on_s = 1'b0;
            end
            default: begin
                fields_on_s = 1'b0;
            end
        endcase
        ra1   = fields_on_s ? src1_s : 2'b00;
        src2  = fields_on_s ? src2_s : {N{1'b0}};
        rdst3 = fields_on_s ? rdst_s : 2'b00;
    end

endmodule

// File: rtl/ctrl_fsm.sv
// Multi-cycle control unit for the Lab2 8-bit datapath: FETCH/DECODE/EXEC/MEM/WB
// sequencing with PC and IR. CTRL_HANDSHAKE_TIMEOUT_EN enables the handshake watchdog.
module ctrl_fsm
    import ctrl_pkg::*;
#(
    parameter int N       = 8,
    parameter int TIMEOUT = 15
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [2*N-1:0] Instr,
    input  logic           InstrValid,
    output logic           InstrReq,
    output logic [N-1:0]   PC,
    input  logic           MemAck,
    output logic           MemReq,
    output logic           MemWE,
    output logic [1:0]     RA1,
    output logic [N-1:0]   Src2,
    output logic [1:0]     RDst3,
    output logic           WE,
    output logic           ALUSrc2,
    output logic           ALUorM,
    output logic [1:0]     ALUCtrl,
    output logic           Err
);

    localparam int CLS_LO = field_lo(N, CLASS_SLOT);

    state_t         state_r;
    state_t         next_state_s;
    logic [2*N-1:0] ir_r;
    logic [N-1:0]   pc_r;
    logic           load_ir_s;
    logic           retire_s;
    logic           timeout_s;
    iclass_t        cls_s;

    assign cls_s = iclass_t'(ir_r[CLS_LO +: FLD_W]);
    assign PC    = pc_r;

`ifdef CTRL_HANDSHAKE_TIMEOUT_EN
    logic [3:0] wait_cnt_r;
    logic       err_r;
    logic       waiting_s;

    assign waiting_s = ((state_r == ST_FETCH) && !InstrValid) ||
                       ((state_r == ST_MEM)   && !MemAck);
    // The TIMEOUT-th consecutive wait cycle is the last one tolerated.
    assign timeout_s = waiting_s && (wait_cnt_r == 4'(TIMEOUT - 1));
    assign Err       = err_r;

    // Wait counter: counts unanswered handshake cycles, restarts on every state change.
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt_r <= 4'd0;
        end else if (next_state_s != state_r) begin
            wait_cnt_r <= 4'd0;
        end else if (waiting_s) begin
            wait_cnt_r <= wait_cnt_r + 4'd1;
        end
    end

    // Sticky error flag, set on entry to ERROR and cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_r <= 1'b0;
        end else if (next_state_s == ST_ERROR) begin
            err_r <= 1'b1;
        end
    end
`else
    logic unused_timeout_s;

    assign timeout_s        = 1'b0;
    assign Err              = 1'b0;
    assign unused_timeout_s = (TIMEOUT != 0);
`endif

    // Next-state logic with IR load and retire strobes.
    always_comb begin
        next_state_s = state_r;
        load_ir_s    = 1'b0;
        retire_s     = 1'b0;
        case (state_r)
            ST_FETCH: begin
                if (InstrValid) begin
                    next_state_s = ST_DECODE;
                    load_ir_s    = 1'b1;
                end else if (timeout_s) begin
                    next_state_s = ST_ERROR;
                end else begin
                    next_state_s = ST_FETCH;
                end
            end
            ST_DECODE: begin
                next_state_s = ST_EXEC;
            end
            ST_EXEC: begin
                if ((cls_s == CLS_LOAD) || (cls_s == CLS_STORE)) begin
                    next_state_s = ST_MEM;
                end else begin
                    next_state_s = ST_WB;
                end
            end
            ST_MEM: begin
                if (MemAck) begin
                    if (cls_s == CLS_STORE) begin
                        next_state_s = ST_FETCH;
                        retire_s     = 1'b1;
                    end else begin
                        next_state_s = ST_WB;
                    end
                end else if (timeout_s) begin
                    next_state_s = ST_ERROR;
                end else begin
                    next_state_s = ST_MEM;
                end
            end
            ST_WB: begin
                next_state_s = ST_FETCH;
                retire_s     = 1'b1;
            end
            ST_ERROR: begin
                next_state_s = ST_ERROR;
            end
            default: begin
                next_state_s = ST_FETCH;
            end
        endcase
    end

    // State, instruction register and program counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_FETCH;
            ir_r    <= {(2*N){1'b0}};
            pc_r    <= {N{1'b0}};
        end else begin
            state_r <= next_state_s;
            if (load_ir_s) begin
                ir_r <= Instr;
            end
            if (retire_s) begin
                pc_r <= pc_r + {{(N-1){1'b0}}, 1'b1};
            end
        end
    end

    ctrl_decode #(
        .N (N)
    ) u_decode (
        .state     (state_r),
        .ir        (ir_r),
        .instr_req (InstrReq),
        .mem_req   (MemReq),
        .mem_we    (MemWE),
        .ra1       (RA1),
        .src2      (Src2),
        .rdst3     (RDst3),
        .we        (WE),
        .alu_src2  (ALUSrc2),
        .alu_or_m  (ALUorM),
        .alu_ctrl  (ALUCtrl)
    );

endmodule

// File: tb/tb_ctrl_fsm.sv
// Self-checking bench for ctrl_fsm: table of instructions with expected per-instruction
// behaviour, scoreboard queue, plus reset, PC wrap, mid-MEM reset and timeout sequences.
module tb_ctrl_fsm;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] Instr;
    logic        InstrValid;
    logic        InstrReq;
    logic [7:0]  PC;
    logic        MemAck;
    logic        MemReq;
    logic        MemWE;
    logic [1:0]  RA1;
    logic [7:0]  Src2;
    logic [1:0]  RDst3;
    logic        WE;
    logic        ALUSrc2;
    logic        ALUorM;
    logic [1:0]  ALUCtrl;
    logic        Err;

    ctrl_fsm #(.N(8), .TIMEOUT(15)) dut (
        .clk        (clk),
        .rst        (rst),
        .Instr      (Instr),
        .InstrValid (InstrValid),
        .InstrReq   (InstrReq),
        .PC         (PC),
        .MemAck     (MemAck),
        .MemReq     (MemReq),
        .MemWE      (MemWE),
        .RA1        (RA1),
        .Src2       (Src2),
        .RDst3      (RDst3),
        .WE         (WE),
        .ALUSrc2    (ALUSrc2),
        .ALUorM     (ALUorM),
        .ALUCtrl    (ALUCtrl),
        .Err        (Err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] cls;
        logic [1:0] func;
        logic [1:0] rdst;
        logic [1:0] src1;
        logic [7:0] src2;
        int         fwait;
        int         mwait;
        int         exp_cycles;
        int         exp_memreq;
        int         exp_memwe;
        int         exp_we;
        logic       exp_aluorm;
        logic       exp_alusrc2;
        logic [1:0] exp_aluctrl;
    } vec_t;

    typedef struct {
        int         cycles;
        int         memreq;
        int         memwe;
        int         we;
        logic       aluorm;
        logic       alusrc2;
        logic [1:0] aluctrl;
        logic [1:0] ra1;
        logic [7:0] src2;
        logic [1:0] rdst3;
        logic [7:0] pc;
    } exp_t;

    int         n_vec = 0;
    int         n_mis = 0;
    vec_t       vecs [8];
    exp_t       sb_q [$];
    logic [7:0] exp_pc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] mk(input logic [1:0] c, input logic [1:0] f,
                                       input logic [1:0] d, input logic [1:0] s1,
                                       input logic [7:0] s2);
        return {c, f, d, s1, s2};
    endfunction

    task automatic run_instr(input vec_t v, input string tag);
        exp_t       e;
        exp_t       want;
        int         cyc = 0;
        int         fw = 0;
        bit         left = 1'b0;
        bit         retired = 1'b0;
        int         unstable = 0;
        int         extra = 0;
        int         memreq_n = 0;
        int         memwe_n = 0;
        int         we_n = 0;
        logic [1:0] ra1_c = 2'b00;
        logic [1:0] rdst_c = 2'b00;
        logic [7:0] src2_c = 8'h00;
        logic       aluorm_c = 1'b0;
        logic       alusrc2_c = 1'b0;
        logic [1:0] aluctrl_c = 2'b00;

        e.cycles  = v.exp_cycles;
        e.memreq  = v.exp_memreq;
        e.memwe   = v.exp_memwe;
        e.we      = v.exp_we;
        e.aluorm  = v.exp_aluorm;
        e.alusrc2 = v.exp_alusrc2;
        e.aluctrl = v.exp_aluctrl;
        e.ra1     = v.src1;
        e.src2    = v.src2;
        e.rdst3   = v.rdst;
        e.pc      = exp_pc + 8'd1;
        sb_q.push_back(e);

        for (cyc = 0; cyc < 80; cyc++) begin
            if (left && InstrReq) begin
                retired    = 1'b1;
                InstrValid = 1'b0;
                MemAck     = 1'b0;
                break;
            end
            if (cyc == v.fwait + 1) begin
                ra1_c  = RA1;
                src2_c = Src2;
                rdst_c = RDst3;
            end else if (cyc > v.fwait + 1 &&
                         (RA1 !== ra1_c || Src2 !== src2_c || RDst3 !== rdst_c)) begin
                unstable++;
            end
            if (cyc == v.fwait + 2) begin
                alusrc2_c = ALUSrc2;
                aluctrl_c = ALUCtrl;
            end else if (ALUSrc2 !== 1'b0 || ALUCtrl !== 2'b00) begin
                extra++;
            end
            if (Err !== 1'b0) extra++;
            if (WE) begin
                we_n++;
                aluorm_c = ALUorM;
            end else if (ALUorM !== 1'b0) begin
                extra++;
            end
            if (MemReq) begin
                memreq_n++;
                if (MemWE) memwe_n++;
            end else if (MemWE !== 1'b0) begin
                extra++;
            end
            // Stimulus for the coming edge; noise on replies outside their handshake window.
            if (InstrReq) begin
                if (fw == v.fwait) begin
                    Instr      = mk(v.cls, v.func, v.rdst, v.src1, v.src2);
                    InstrValid = 1'b1;
                    left       = 1'b1;
                end else begin
                    Instr      = 16'($urandom);
                    InstrValid = 1'b0;
                    fw++;
                end
            end else begin
                Instr      = 16'($urandom);
                InstrValid = 1'($urandom);
            end
            if (MemReq) MemAck = (memreq_n > v.mwait);
            else        MemAck = 1'($urandom);
            @(negedge clk);
        end

        check({tag, "_retired"}, 32'(retired), 32'd1);
        exp_pc = exp_pc + 8'd1;
        want = sb_q.pop_front();
        check({tag, "_cycles"},   cyc,       want.cycles);
        check({tag, "_memreq"},   memreq_n,  want.memreq);
        check({tag, "_memwe"},    memwe_n,   want.memwe);
        check({tag, "_we"},       we_n,      want.we);
        check({tag, "_aluorm"},   aluorm_c,  want.aluorm);
        check({tag, "_alusrc2"},  alusrc2_c, want.alusrc2);
        check({tag, "_aluctrl"},  aluctrl_c, want.aluctrl);
        check({tag, "_ra1"},      ra1_c,     want.ra1);
        check({tag, "_src2"},     src2_c,    want.src2);
        check({tag, "_rdst3"},    rdst_c,    want.rdst3);
        check({tag, "_stable"},   unstable,  32'd0);
        check({tag, "_spurious"}, extra,     32'd0);
        check({tag, "_pc"},       PC,        want.pc);
    endtask

    initial begin
        bit found;

        //             cls   func  rdst  src1  src2  fw mw  cyc mrq mwe we aluorm alusrc2 aluctrl
        vecs[0] = '{2'd0, 2'd0, 2'd1, 2'd2, 8'hC0, 0, 0,  4,  0,  0,  1, 1'b0, 1'b0, 2'd0};
        vecs[1] = '{2'd2, 2'd3, 2'd2, 2'd1, 8'h05, 0, 3,  8,  4,  0,  1, 1'b1, 1'b1, 2'd0};
        vecs[2] = '{2'd3, 2'd2, 2'd0, 2'd3, 8'h40, 0, 0,  4,  1,  1,  0, 1'b0, 1'b0, 2'd0};
        vecs[3] = '{2'd1, 2'd1, 2'd3, 2'd0, 8'hA5, 2, 0,  6,  0,  0,  1, 1'b0, 1'b1, 2'd1};
        vecs[4] = '{2'd0, 2'd2, 2'd2, 2'd3, 8'h80, 1, 0,  5,  0,  0,  1, 1'b0, 1'b0, 2'd2};
        vecs[5] = '{2'd1, 2'd3, 2'd0, 2'd1, 8'hFF, 0, 0,  4,  0,  0,  1, 1'b0, 1'b1, 2'd3};
        vecs[6] = '{2'd3, 2'd1, 2'd1, 2'd2, 8'h00, 1, 2,  7,  3,  3,  0, 1'b0, 1'b0, 2'd0};
        vecs[7] = '{2'd2, 2'd0, 2'd3, 2'd3, 8'h7E, 0, 0,  5,  1,  0,  1, 1'b1, 1'b1, 2'd0};

        rst        = 1'b1;
        Instr      = 16'h0000;
        InstrValid = 1'b0;
        MemAck     = 1'b0;
        exp_pc     = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_instrreq", InstrReq, 32'd1);
        check("rst_pc",       PC,       32'd0);
        check("rst_mem",      {MemReq, MemWE}, 32'd0);
        check("rst_regctl",   {WE, ALUSrc2, ALUorM, ALUCtrl}, 32'd0);
        check("rst_fields",   {RA1, Src2, RDst3}, 32'd0);
        check("rst_err",      Err, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            run_instr(vecs[i], $sformatf("v%0d", i));
        end

        // Reset while a STORE waits in MEM.
        Instr      = mk(2'd3, 2'd0, 2'd0, 2'd1, 8'h80);
        InstrValid = 1'b1;
        MemAck     = 1'b0;
        @(negedge clk);
        InstrValid = 1'b0;
        found      = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (MemReq) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("midmem_memreq_seen", 32'(found), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("midmem_memreq", MemReq,   32'd0);
        check("midmem_memwe",  MemWE,    32'd0);
        check("midmem_instrreq", InstrReq, 32'd1);
        check("midmem_pc",     PC,       32'd0);
        rst    = 1'b0;
        exp_pc = 8'h00;

        while (exp_pc != 8'hFF) begin
            run_instr(vecs[0], "walk");
        end
        run_instr(vecs[5], "wrap");
        check("pc_wrap", PC, 32'h00);

`ifdef CTRL_HANDSHAKE_TIMEOUT_EN
        InstrValid = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (i == 13) begin
                check("to_pre_instrreq", InstrReq, 32'd1);
                check("to_pre_err",      Err,      32'd0);
            end
        end
        check("to_err",      Err,      32'd1);
        check("to_instrreq", InstrReq, 32'd0);
        InstrValid = 1'b1;
        MemAck     = 1'b1;
        repeat (3) @(negedge clk);
        check("to_err_sticky", Err, 32'd1);
        check("to_quiet", {InstrReq, MemReq, MemWE, WE}, 32'd0);
        InstrValid = 1'b0;
        MemAck     = 1'b0;
        rst        = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("to_rst_err",      Err,      32'd0);
        check("to_rst_instrreq", InstrReq, 32'd1);
        exp_pc = 8'h00;
        run_instr(vecs[2], "post_to");
`else
        InstrValid = 1'b0;
        repeat (20) @(negedge clk);
        check("nowait_instrreq", InstrReq, 32'd1);
        check("nowait_err",      Err,      32'd0);
        run_instr(vecs[1], "post_wait");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
